// File: rtl/xip_fetch_arbiter_pkg.sv
// xip_pkg: shared constants and FSM state type for the XIP fetch arbiter.
//   AHB encodings used by the single-read master, the default flash
//   address width and the arbiter FSM state enum.
package xip_pkg;

  localparam int XIP_ADDR_W = 24;
  localparam int HADDR_W    = 36;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_64      = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HIT  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    RESP = 3'd4
  } xip_state_e;

endpackage

// File: rtl/xip_fetch_arbiter_if.sv
// xip_ahb_if: AHB-lite read segment between the fetch arbiter and the XIP
// slave.
//   master: drives HSEL/HADDR/HTRANS/HSIZE/HBURST/HWRITE, samples
//           HREADY/HRDATA.
//   slave : the mirror image.
interface xip_ahb_if;
  import xip_pkg::*;

  logic               HSEL;
  logic [HADDR_W-1:0] HADDR;
  logic [1:0]         HTRANS;
  logic [2:0]         HSIZE;
  logic [2:0]         HBURST;
  logic               HWRITE;
  logic               HREADY;
  logic [63:0]        HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HBURST, HWRITE,
    input  HREADY, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HBURST, HWRITE,
    output HREADY, HRDATA
  );
endinterface

// File: rtl/xip_fetch_arbiter_rr_arb2.sv
// xip_rr_arb2: two-way round-robin picker.
//   clk, rst : clock, synchronous active-high reset
//   i_req    : request vector {port1, port0}
//   i_grant  : the grant is taken this cycle; record the winner
//   o_any    : at least one request present
//   o_win    : winning port index
// r_rr_last resets to 1 so port 0 wins the first tie.
module xip_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_grant,
  output logic       o_any,
  output logic       o_win
);
  logic r_rr_last;

  assign o_any = |i_req;
  // On a tie the port that did not win last time takes it.
  assign o_win = (&i_req) ? ~r_rr_last : i_req[1];

  always_ff @(posedge clk) begin
    if (rst)          r_rr_last <= 1'b1;
    else if (i_grant) r_rr_last <= o_win;
  end
endmodule

// File: rtl/xip_fetch_arbiter.sv
// xip_fetch_arbiter: shares the QPI XIP read engine between instruction
// fetch (port 0) and data load (port 1). Issues 64-bit AHB SINGLE reads
// and keeps a one-doubleword line buffer for repeat hits.
//   HCLK, HRESET          : clock, synchronous active-high reset
//   reqN_valid/reqN_addr  : request, held until rspN_valid
//   rspN_valid            : one-cycle response pulse
//   rsp_data              : shared response doubleword
//   flush                 : invalidate line buffer
//   xip_ready             : sticky, set by first HREADY=1 after reset
//   ahb                   : AHB master toward the XIP slave
module xip_fetch_arbiter
  import xip_pkg::*;
#(
  parameter int ADDR_W = XIP_ADDR_W,
  parameter bit BUF_EN = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              rsp1_valid,
  output logic [63:0]       rsp_data,
  input  logic              flush,
  output logic              xip_ready,
  xip_ahb_if.master         ahb
);
  localparam int DW_W = ADDR_W - 3;

  xip_state_e      r_state, w_nxt;
  logic            r_win;
  logic [DW_W-1:0] r_adw;        // latched doubleword address of the grant
  logic            r_buf_vld;
  logic [DW_W-1:0] r_buf_tag;
  logic [63:0]     r_buf_data;
  logic [63:0]     r_rsp_data;
  logic            r_xip_ready;

  logic [1:0]      w_req;
  logic            w_any, w_arb_win, w_grant, w_hit, w_issue, w_cap;
  logic [DW_W-1:0] w_req_dw;
  logic            w_unused;

  assign w_req = {req1_valid, req0_valid};

  xip_rr_arb2 u_arb (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_req   (w_req),
    .i_grant (w_grant),
    .o_any   (w_any),
    .o_win   (w_arb_win)
  );

  // Byte offset within the doubleword never reaches the bus.
  assign w_unused = ^{req0_addr[2:0], req1_addr[2:0]};
  assign w_req_dw = w_arb_win ? req1_addr[ADDR_W-1:3] : req0_addr[ADDR_W-1:3];
  // A flush in the grant cycle already disqualifies the buffer.
  assign w_hit    = BUF_EN && r_buf_vld && (r_buf_tag == w_req_dw) && !flush;
  assign w_cap    = (r_state == DATA) && ahb.HREADY;

  always_comb begin
    w_nxt   = r_state;
    w_grant = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_grant = 1'b1;
        w_nxt   = w_hit ? HIT : ADDR;
      end
      HIT:  w_nxt = RESP;
      // Slave holds HREADY low during flash init; no address phase until
      // xip_ready has been seen.
      ADDR: if (r_xip_ready && ahb.HREADY) begin
        w_issue = 1'b1;
        w_nxt   = DATA;
      end
      DATA: if (ahb.HREADY) w_nxt = RESP;
      RESP: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= IDLE;
      r_win       <= 1'b0;
      r_adw       <= '0;
      r_buf_vld   <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_rsp_data  <= '0;
      r_xip_ready <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_xip_ready <= r_xip_ready | ahb.HREADY;
      if (w_grant) begin
        r_win <= w_arb_win;
        r_adw <= w_req_dw;
      end
      if (r_state == HIT) r_rsp_data <= r_buf_data;
      if (w_cap) begin
        r_rsp_data <= ahb.HRDATA;
        r_buf_data <= ahb.HRDATA;
        r_buf_tag  <= r_adw;
      end
      // Flush wins over a coincident fill: data delivered, line stays invalid.
      if (flush)      r_buf_vld <= 1'b0;
      else if (w_cap) r_buf_vld <= 1'b1;
    end
  end

  assign rsp0_valid = (r_state == RESP) && !r_win;
  assign rsp1_valid = (r_state == RESP) &&  r_win;
  assign rsp_data   = r_rsp_data;
  assign xip_ready  = r_xip_ready;

  always_comb begin
    ahb.HADDR = '0;
    if (r_state == ADDR) ahb.HADDR[ADDR_W-1:3] = r_adw;
  end

  assign ahb.HSEL   = w_issue;
  assign ahb.HTRANS = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb.HSIZE  = HSIZE_64;
  assign ahb.HBURST = HBURST_SINGLE;
  assign ahb.HWRITE = 1'b0;
endmodule

// File: tb/tb_xip_fetch_arbiter.sv
// Directed bench for xip_fetch_arbiter: init gate, hit, wait states,
// flush on fill, reset mid-transfer, round-robin.
module tb_xip_fetch_arbiter;
  import xip_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0;
  logic [23:0] req0_addr = '0, req1_addr = '0;
  logic        rsp0_valid, rsp1_valid, xip_ready;
  logic [63:0] rsp_data;

  xip_ahb_if ahb ();

  xip_fetch_arbiter #(.ADDR_W(24), .BUF_EN(1'b1)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .rsp0_valid (rsp0_valid),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .xip_ready  (xip_ready),
    .ahb        (ahb)
  );

  always #5 HCLK = ~HCLK;

  int          n_cmp = 0, n_err = 0;
  int          nonseq_cnt = 0, ovl_cnt = 0;
  logic [35:0] last_haddr = '0;
  int          lat, base, k, bad, seen;
  int          order [4];
  logic [63:0] d;

  // Bus monitor, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (ahb.HSEL && ahb.HTRANS == HTRANS_NONSEQ) begin
      nonseq_cnt++;
      last_haddr = ahb.HADDR;
    end
    if (rsp0_valid && rsp1_valid) ovl_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK); #1;
  endtask

  task automatic wait_rsp(input int port, input int budget, output int l, output logic [63:0] dat);
    l = -1; dat = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge HCLK);
      if ((port == 0) ? rsp0_valid : rsp1_valid) begin
        l = c; dat = rsp_data; break;
      end
    end
    cyc();
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic req_wait(input int port, input logic [23:0] a, input int budget,
                          output int l, output logic [63:0] dat);
    cyc();
    if (port == 0) begin req0_addr = a; req0_valid = 1'b1; end
    else           begin req1_addr = a; req1_valid = 1'b1; end
    wait_rsp(port, budget, l, dat);
  endtask

  initial begin
    ahb.HREADY = 1'b0;
    ahb.HRDATA = '0;
    repeat (3) cyc();
    @(negedge HCLK);
    chk("rst_rsp0",   64'(rsp0_valid), 64'd0);
    chk("rst_rsp1",   64'(rsp1_valid), 64'd0);
    chk("rst_data",   rsp_data, 64'd0);
    chk("rst_xrdy",   64'(xip_ready), 64'd0);
    chk("rst_hsel",   64'(ahb.HSEL), 64'd0);
    chk("rst_htrans", 64'(ahb.HTRANS), 64'd0);
    chk("rst_haddr",  64'(ahb.HADDR), 64'd0);
    chk("hsize",      64'(ahb.HSIZE), 64'd3);
    chk("hburst",     64'(ahb.HBURST), 64'd0);
    chk("hwrite",     64'(ahb.HWRITE), 64'd0);
    cyc(); HRESET = 1'b0;

    // Init gate: HREADY low for 50 cycles, no address phase may appear.
    ahb.HRDATA = 64'h1111_2222_3333_4444;
    req0_addr = 24'h000100; req0_valid = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge HCLK);
      if (rsp0_valid) seen = 1;
      cyc();
    end
    chk("init_nonseq", 64'(nonseq_cnt), 64'd0);
    chk("init_rsp",    64'(seen), 64'd0);
    chk("init_xrdy",   64'(xip_ready), 64'd0);
    ahb.HREADY = 1'b1;
    wait_rsp(0, 10, lat, d);
    chk("init_lat",    64'(lat), 64'd3);
    chk("init_data",   d, 64'h1111_2222_3333_4444);
    chk("init_cnt",    64'(nonseq_cnt), 64'd1);
    chk("init_haddr",  64'(last_haddr), 64'h100);
    chk("init_xrdy1",  64'(xip_ready), 64'd1);

    // Fill 0x108 from port 0, then port 1 hits the same doubleword.
    ahb.HRDATA = 64'hA5A5_0108_DEAD_BEEF;
    req_wait(0, 24'h000108, 10, lat, d);
    chk("fill_lat",   64'(lat), 64'd3);
    chk("fill_data",  d, 64'hA5A5_0108_DEAD_BEEF);
    chk("fill_haddr", 64'(last_haddr), 64'h108);
    ahb.HRDATA = 64'h0;
    base = nonseq_cnt;
    req_wait(1, 24'h00010C, 10, lat, d);
    chk("hit_lat",  64'(lat), 64'd2);
    chk("hit_data", d, 64'hA5A5_0108_DEAD_BEEF);
    chk("hit_nobus", 64'(nonseq_cnt), 64'(base));

    // Seven wait states in DATA; garbage on HRDATA while HREADY is low.
    cyc(); req0_addr = 24'h000200; req0_valid = 1'b1;
    @(negedge HCLK); cyc();
    @(negedge HCLK);
    chk("ws_htrans", 64'(ahb.HTRANS), 64'(HTRANS_NONSEQ));
    chk("ws_hsel",   64'(ahb.HSEL), 64'd1);
    chk("ws_haddr",  64'(ahb.HADDR), 64'h200);
    cyc(); ahb.HREADY = 1'b0; ahb.HRDATA = 64'hBAD0_BAD0_BAD0_BAD0;
    bad = 0;
    repeat (7) begin
      @(negedge HCLK);
      if (ahb.HTRANS != HTRANS_IDLE || ahb.HSEL || rsp0_valid) bad++;
      cyc();
    end
    chk("ws_idle", 64'(bad), 64'd0);
    ahb.HREADY = 1'b1; ahb.HRDATA = 64'h0123_4567_89AB_CDEF;
    wait_rsp(0, 4, lat, d);
    chk("ws_lat",  64'(lat), 64'd1);
    chk("ws_data", d, 64'h0123_4567_89AB_CDEF);

    // Flush coincident with the DATA capture.
    ahb.HRDATA = 64'hF1F1_0300_0000_0001;
    cyc(); req0_addr = 24'h000300; req0_valid = 1'b1;
    @(negedge HCLK); cyc();
    @(negedge HCLK); cyc();
    flush = 1'b1;
    @(negedge HCLK); cyc();
    flush = 1'b0;
    @(negedge HCLK);
    chk("fl_rsp",  64'(rsp0_valid), 64'd1);
    chk("fl_data", rsp_data, 64'hF1F1_0300_0000_0001);
    cyc(); req0_valid = 1'b0;
    ahb.HRDATA = 64'hF2F2_0300_0000_0002;
    base = nonseq_cnt;
    req_wait(0, 24'h000300, 10, lat, d);
    chk("fl_miss_lat",  64'(lat), 64'd3);
    chk("fl_miss_data", d, 64'hF2F2_0300_0000_0002);
    chk("fl_miss_bus",  64'(nonseq_cnt), 64'(base + 1));

    // Reset while stalled in DATA; 0x300 is buffered and valid beforehand.
    cyc(); req0_addr = 24'h000400; req0_valid = 1'b1;
    @(negedge HCLK); cyc();
    @(negedge HCLK); cyc();
    HRESET = 1'b1; ahb.HREADY = 1'b0;
    @(negedge HCLK); cyc();
    @(negedge HCLK);
    chk("mrst_rsp0",   64'(rsp0_valid), 64'd0);
    chk("mrst_rsp1",   64'(rsp1_valid), 64'd0);
    chk("mrst_data",   rsp_data, 64'd0);
    chk("mrst_xrdy",   64'(xip_ready), 64'd0);
    chk("mrst_hsel",   64'(ahb.HSEL), 64'd0);
    chk("mrst_htrans", 64'(ahb.HTRANS), 64'd0);
    chk("mrst_haddr",  64'(ahb.HADDR), 64'd0);
    cyc();
    HRESET = 1'b0; req0_valid = 1'b0; ahb.HREADY = 1'b1;
    ahb.HRDATA = 64'h5EED_0300_0000_0003;
    base = nonseq_cnt;
    req_wait(1, 24'h000300, 10, lat, d);
    chk("mrst_lat",   64'(lat), 64'd3);
    chk("mrst_fresh", d, 64'h5EED_0300_0000_0003);
    chk("mrst_bus",   64'(nonseq_cnt), 64'(base + 1));
    chk("mrst_haddr2", 64'(last_haddr), 64'h300);

    // Both ports held high: grants alternate 0,1,0,1.
    ahb.HRDATA = 64'h0000_0800_0000_0000;
    base = nonseq_cnt;
    cyc();
    req0_addr = 24'h000000; req1_addr = 24'h000800;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge HCLK);
      if (rsp0_valid && !rsp1_valid) begin order[k] = 0; k++; end
      else if (rsp1_valid && !rsp0_valid) begin order[k] = 1; k++; end
    end
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", 64'(k), 64'd4);
    chk("rr_g0", 64'(order[0]), 64'd0);
    chk("rr_g1", 64'(order[1]), 64'd1);
    chk("rr_g2", 64'(order[2]), 64'd0);
    chk("rr_g3", 64'(order[3]), 64'd1);
    chk("rr_bus", 64'(nonseq_cnt), 64'(base + 4));
    chk("no_overlap", 64'(ovl_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xip_fetch_arbiter.md
Name: xip_fetch_arbiter

Overview:
Shares the single QPI XIP flash read engine between two read-only requesters: port 0 (instruction fetch) and port 1 (data load). It acts as an AHB master toward the XIP slave and issues only 64-bit single reads. A one-entry doubleword line buffer returns repeat hits without a flash access. It sits between the core's fetch/load units and the XIP slave on the flash-side AHB segment.

Parameters:
ADDR_W, 24, flash byte-address width (16 MiB window)
BUF_EN, 1, 1 = line buffer enabled; 0 = every request goes to the bus

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
req0_valid  in  1  port 0 request; held high until rsp0_valid
req0_addr  in  ADDR_W  port 0 byte address; stable while req0_valid
rsp0_valid  out  1  one-cycle pulse; rsp_data valid for port 0
req1_valid  in  1  port 1 request; same rules as port 0
req1_addr  in  ADDR_W  port 1 byte address
rsp1_valid  out  1  one-cycle pulse for port 1
rsp_data  out  64  doubleword at {addr[ADDR_W-1:3],3'b000}, shared by both ports
flush  in  1  invalidate line buffer
xip_ready  out  1  sticky high once downstream HREADY is first sampled high
HSEL  out  1  AHB select to XIP slave
HADDR  out  36  {zero-extend, addr[ADDR_W-1:3], 3'b000}
HTRANS  out  2  IDLE=2'b00 / NONSEQ=2'b10
HSIZE  out  3  fixed 3'b011
HBURST  out  3  fixed 3'b000 (SINGLE)
HWRITE  out  1  fixed 0
HREADY  in  1  XIP slave ready
HRDATA  in  64  XIP slave read data

Behaviour:
- Reset values: rsp0_valid=rsp1_valid=0, rsp_data=0, xip_ready=0, HSEL=0, HTRANS=IDLE, HADDR=0, buffer invalid, rr_last=1 (port 0 wins first tie).
- Reset is synchronous and active-high, and applies on any cycle, including mid-transfer. FSM returns to IDLE. Any pending response is dropped; requesters must re-request.
- FSM states:
  - IDLE: arbitrate.
  - HIT: respond from buffer.
  - ADDR: drive address phase.
  - DATA: wait on HREADY.
  - RESP: pulse rsp.
- IDLE, no valid request: stay in IDLE, HTRANS=IDLE, HSEL=0.
- Arbitration in IDLE, among valid requests:
  - Single requester wins.
  - Both valid: the port not equal to rr_last wins.
  - rr_last updates to the winner on the grant cycle.
  - Winner index and address are latched into win/alat.
- Hit test: BUF_EN=1, buffer valid, tag==alat[ADDR_W-1:3], and no flush this cycle. Hit -> HIT -> RESP. Hit latency is 2 cycles from the grant cycle to the rsp pulse.
- Miss -> ADDR. ADDR waits until xip_ready=1 and HREADY=1. In that cycle it drives HSEL=1, HTRANS=NONSEQ and HADDR, then moves to DATA. HSEL and HTRANS return to 0/IDLE in DATA.
- DATA: each cycle HREADY=0 -> stay. HREADY=1 -> capture HRDATA into rsp_data and the buffer; tag<=alat[ADDR_W-1:3]; valid<=1 unless flush is high that cycle; go to RESP.
- RESP: rsp{win}_valid=1 for exactly one cycle, then IDLE. The requester drops req in the following cycle. A request still high in IDLE after RESP is treated as a new request.
- Only one response pulse at a time; rsp0_valid and rsp1_valid are never high together.
- flush in any state clears valid next cycle. flush coincident with a DATA capture: data is still delivered, but the buffer stays invalid.
- xip_ready: set on the first cycle HREADY=1 after reset. Until then no address phase is issued, because the XIP slave holds HREADY low during flash init.
- No starvation: with both ports continuously requesting, grants alternate 0,1,0,1.

Decomposition:
- Shared package xip_pkg: HTRANS_IDLE/NONSEQ, HSIZE_64, HBURST_SINGLE, FSM state enum (IDLE,HIT,ADDR,DATA,RESP), XIP_ADDR_W=24.
- One sub-module, xip_rr_arb2: 2-way round-robin picker with rr_last register. Everything else stays in the top module.

Test Plan:
- Init gate: HREADY held 0 for 50 cycles after reset, req0 at 0x000100 -> no HTRANS=NONSEQ before HREADY rises. Then one NONSEQ with HADDR=0x100, and rsp0 carries the HRDATA value.
- Hit: req0 0x000108, then req1 0x00010C -> second request issues no bus transfer; rsp1_valid 2 cycles after grant with the same 64-bit data.
- Round-robin: req0 and req1 held continuously at 0x0 and 0x800 with BUF_EN=0 -> grant order 0,1,0,1; rsp pulses never overlap.
- Flush on fill: flush asserted in the DATA cycle where HREADY=1 -> rsp delivered. An immediate re-request of the same address goes to the bus (miss).
- Wait states: slave inserts 7 HREADY=0 cycles in DATA -> FSM holds DATA and captures only on the HREADY=1 cycle. HTRANS stays IDLE during the wait.
- Reset mid-transfer: HRESET in DATA -> next cycle all outputs at reset values and the buffer is invalid. A req1 after release gets a fresh NONSEQ.
